// File: rtl/cpc_ramexp_ctrl.sv
// cpc_ramexp_ctrl: CPC RAM-expansion controller with banked port decode, base-RAM shadow
// and 464-style overdrive of RD*/A15 during expansion writes.
module cpc_ramexp_ctrl #(
    parameter int NBANK_BITS   = 3,
    parameter bit SHADOW_EN    = 1'b1,
    parameter bit OVERDRIVE_EN = 1'b1,
    parameter int SHADOW_BANK  = 2**NBANK_BITS-1
) (
    input  logic                  clk,
    input  logic                  reset_b,
    inout  wire                   adr15,
    input  logic                  adr14,
    input  logic [5:0]            adr_io,
    input  logic                  iorq_b,
    input  logic                  mreq_b,
    input  logic                  m1_b,
    input  logic                  rfsh_b,
    input  logic                  wr_b,
    inout  wire                   rd_b,
    input  logic                  ready,
    input  logic [7:0]            data,
    output logic                  ramdis,
    output logic                  ramcs_b,
    output logic                  ramoe_b,
    output logic                  ramwe_b,
    output logic [NBANK_BITS+1:0] ramadrhi,
    output logic [NBANK_BITS+2:0] cfg_q
);
    localparam int NB = NBANK_BITS;
    localparam logic [NB-1:0] SB = NB'(SHADOW_BANK);

    typedef enum logic [1:0] {ST_IDLE, ST_T1, ST_T2, ST_END} state_t;

    state_t        state_q, state_d;
    logic          ready_q, io_q, armed_q, hold_q, a15_q;
    logic          io_wr, load, mwr, mwr_d, a15h, c000, p4000;
    logic          exp_hit, rd_shadow, wr_shadow, rd_oe, a15_oe;
    logic [2:0]    mode;
    logic [1:0]    blk;
    logic [NB-1:0] bank, eb, bank_ld;
    logic          unused_ok;

    assign mode      = cfg_q[2:0];
    assign bank      = cfg_q[NB+2:3];
    assign io_wr     = !iorq_b && !wr_b && m1_b && !adr15 && data[7:6] == 2'b11;
    assign load      = io_wr && io_q && armed_q;
    assign bank_ld   = NB'({~adr_io[5:3], data[5:3]});
    assign mwr_d     = state_d == ST_T1 || state_d == ST_T2;
    assign unused_ok = ^adr_io[2:0];

    // The address hold is stretched while the write machine is busy so the
    // overdriven A15 never feeds back into the decode.
    always_ff @(posedge clk or negedge reset_b)
        if (!reset_b) begin
            cfg_q   <= '0;
            io_q    <= 1'b0;
            armed_q <= 1'b1;
            ready_q <= 1'b1;
            hold_q  <= 1'b0;
            a15_q   <= 1'b0;
        end else begin
            io_q    <= io_wr;
            armed_q <= iorq_b || (armed_q && !load);
            ready_q <= ready;
            hold_q  <= !mreq_b || (hold_q && mwr_d);
            if (load) cfg_q <= {bank_ld, data[2:0]};
            if (!mreq_b && !hold_q) a15_q <= adr15;
        end

    always_ff @(posedge clk or negedge reset_b)
        if (!reset_b) state_q <= ST_IDLE;
        else          state_q <= state_d;

    always_comb
        state_d = (state_q == ST_T1) ? (ready_q ? ST_T2 : ST_T1)
                : (state_q == ST_T2) ? ST_END
                : (!mreq_b && rfsh_b && m1_b && rd_b) ? ST_T1 : ST_IDLE;

    always_comb begin
        mwr    = state_q == ST_T1 || state_q == ST_T2;
        rd_oe  = OVERDRIVE_EN && exp_hit && mwr;
        a15_oe = OVERDRIVE_EN && mode == 3'd3 && hold_q && !a15_q && adr14
                 && (mwr || (!SHADOW_EN && !mreq_b));
    end

    always_comb begin
        a15h      = hold_q ? a15_q : adr15;
        c000      = a15h && adr14;
        p4000     = !a15h && adr14;
        eb        = (SHADOW_EN && bank == SB) ? SB ^ NB'(1) : bank;
        exp_hit   = (mode == 3'd1 || mode == 3'd3) ? c000
                  : (mode == 3'd2) ? 1'b1
                  : mode[2] ? p4000 : 1'b0;
        blk       = (mode == 3'd2) ? {a15h, adr14} : mode[2] ? mode[1:0] : 2'b11;
        rd_shadow = SHADOW_EN && mode == 3'd3 && p4000 && !rd_b;
        wr_shadow = SHADOW_EN && !exp_hit && !wr_b && (c000 || (mode == 3'd3 && p4000));
        ramdis    = exp_hit || rd_shadow;
        ramcs_b   = mreq_b || !rfsh_b || !(exp_hit || rd_shadow || wr_shadow);
        ramadrhi  = exp_hit ? {eb, blk} : {SB, 2'b11};
    end

    assign ramoe_b = rd_b;
    assign ramwe_b = wr_b;
    assign rd_b    = rd_oe ? 1'b0 : 1'bz;
    assign adr15   = a15_oe ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_cpc_ramexp_ctrl.sv
// tb_cpc_ramexp_ctrl: directed and randomized checks of the 4MB build against a page-level mapping model.
`timescale 1ns/1ps
module tb_cpc_ramexp_ctrl;
    logic       clk = 1'b0, reset_b = 1'b0;
    logic       adr14 = 1'b0, iorq_b = 1'b1, mreq_b = 1'b1, m1_b = 1'b1, rfsh_b = 1'b1, wr_b = 1'b1;
    logic       ready = 1'b1;
    logic [5:0] adr_io = '0;
    logic [7:0] data = '0;
    logic       a15_hi = 1'b0, rd_lo = 1'b0;
    logic       ramdis, ramcs_b, ramoe_b, ramwe_b;
    logic [7:0] ramadrhi;
    logic [8:0] cfg_q;
    wire        adr15, rd_b;

    logic [5:0] m_bank = '0;
    logic [2:0] m_mode = '0;
    int         n_chk = 0, n_fail = 0;

    // Z80 side behaves open-drain so the controller's overdrive is visible on the nets.
    assign adr15 = a15_hi ? 1'b1 : 1'bz;
    assign rd_b  = rd_lo ? 1'b0 : 1'bz;
    pulldown (adr15);
    pullup (rd_b);

    always #125 clk = ~clk;

    cpc_ramexp_ctrl #(.NBANK_BITS(6), .SHADOW_EN(1'b1), .OVERDRIVE_EN(1'b1), .SHADOW_BANK(63)) dut (
        .clk(clk), .reset_b(reset_b), .adr15(adr15), .adr14(adr14), .adr_io(adr_io),
        .iorq_b(iorq_b), .mreq_b(mreq_b), .m1_b(m1_b), .rfsh_b(rfsh_b), .wr_b(wr_b),
        .rd_b(rd_b), .ready(ready), .data(data), .ramdis(ramdis), .ramcs_b(ramcs_b),
        .ramoe_b(ramoe_b), .ramwe_b(ramwe_b), .ramadrhi(ramadrhi), .cfg_q(cfg_q));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    // Mapping by 16K page: returns {ramdis, sram selected, ramadrhi}.
    function automatic logic [9:0] model(input logic [15:0] a, input bit wr,
                                         input logic [2:0] mode, input logic [5:0] bank);
        int pg, blk;
        logic [5:0] eb;
        pg  = int'(a[15:14]);
        eb  = (bank == 6'd63) ? 6'd62 : bank;
        blk = -1;
        if ((mode == 3'd1 || mode == 3'd3) && pg == 3) blk = 3;
        if (mode == 3'd2) blk = pg;
        if (mode >= 3'd4 && pg == 1) blk = int'(mode) - 4;
        if (blk >= 0) return {2'b11, eb, 2'(blk)};
        if (mode == 3'd3 && pg == 1 && !wr) return {2'b11, 8'hFF};
        if (wr && (pg == 3 || (mode == 3'd3 && pg == 1))) return {2'b01, 8'hFF};
        return 10'd0;
    endfunction

    task automatic set_addr(input logic [15:0] a);
        a15_hi = a[15];
        adr14  = a[14];
        adr_io = a[13:8];
    endtask

    task automatic check_map(input logic [15:0] a, input bit wr, input bit rf);
        logic [9:0] e;
        e = model(a, wr, m_mode, m_bank);
        chk($sformatf("ramdis@%h", a), ramdis, e[9]);
        chk($sformatf("ramcs_b@%h", a), ramcs_b, rf ? 1'b1 : !e[8]);
        if (!rf && e[8]) chk($sformatf("ramadrhi@%h", a), ramadrhi, e[7:0]);
    endtask

    task automatic mem_rd(input logic [15:0] a, input bit rf);
        @(negedge clk);
        set_addr(a);
        mreq_b = 1'b0;
        rfsh_b = !rf;
        rd_lo  = !rf;
        #20 check_map(a, 1'b0, rf);
        @(negedge clk);
        mreq_b = 1'b1;
        rfsh_b = 1'b1;
        rd_lo  = 1'b0;
    endtask

    // d is presented for the first two samples, d2 for any further ones.
    task automatic io_out(input logic [5:0] aio, input logic [7:0] d, input int n, input logic [7:0] d2);
        @(negedge clk);
        a15_hi = 1'b0;
        adr14  = 1'b1;
        adr_io = aio;
        data   = d;
        iorq_b = 1'b0;
        wr_b   = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 2) data = d2;
        end
        iorq_b = 1'b1;
        wr_b   = 1'b1;
        @(negedge clk);
        if (n >= 2) begin
            m_mode = d[2:0];
            m_bank = {~aio[5:3], d[5:3]};
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ra;
        logic [7:0] d1, d2;
        int n;
        repeat (2) @(negedge clk);
        chk("reset cfg_q", cfg_q, 9'd0);
        chk("reset ramdis", ramdis, 1'b0);
        chk("reset ramcs_b", ramcs_b, 1'b1);
        chk("reset rd_b released", rd_b, 1'b1);
        chk("reset adr15 released", adr15, 1'b0);
        reset_b = 1'b1;
        mem_rd(16'hC123, 1'b0);
        chk("cfg_q after read", cfg_q, 9'd0);

        io_out(6'b011000, 8'hD1, 2, 8'hD1);
        chk("cfg_q bank34 mode1", cfg_q, {6'b100010, 3'd1});
        mem_rd(16'hC000, 1'b0);
        mem_rd(16'h4000, 1'b0);
        mem_rd(16'hC000, 1'b1);

        io_out(6'b000000, 8'hC2, 1, 8'hC2);
        chk("cfg_q short strobe", cfg_q, {6'b100010, 3'd1});
        io_out(6'b000000, 8'hC5, 4, 8'hFF);
        chk("cfg_q single load", cfg_q, {6'd56, 3'd5});
        mem_rd(16'h4000, 1'b0);

        // mode 2 write with two wait cycles
        io_out(6'b110000, 8'hEA, 2, 8'hEA);
        chk("cfg_q bank13 mode2", cfg_q, {6'd13, 3'd2});
        @(negedge clk);
        set_addr(16'h4000);
        mreq_b = 1'b0;
        wr_b   = 1'b0;
        ready  = 1'b0;
        #20 check_map(16'h4000, 1'b1, 1'b0);
        chk("wr idle rd_b", rd_b, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #20 chk($sformatf("wr mwr%0d rd_b", i), rd_b, 1'b0);
            if (i == 1) ready = 1'b1;
            if (i == 3) begin mreq_b = 1'b1; wr_b = 1'b1; end
        end
        @(negedge clk);
        #20 chk("wr end rd_b", rd_b, 1'b1);
        @(negedge clk);
        #20 chk("wr idle2 rd_b", rd_b, 1'b1);

        // reserved bank in mode 3
        io_out(6'b000000, 8'hFB, 2, 8'hFB);
        chk("cfg_q bank63 mode3", cfg_q, {6'd63, 3'd3});
        mem_rd(16'hC000, 1'b0);
        @(negedge clk);
        set_addr(16'h4000);
        mreq_b = 1'b0;
        wr_b   = 1'b0;
        #20 check_map(16'h4000, 1'b1, 1'b0);
        chk("m3 idle adr15", adr15, 1'b0);
        @(negedge clk);
        #20 chk("m3 T1 adr15", adr15, 1'b1);
        check_map(16'h4000, 1'b1, 1'b0);
        chk("m3 T1 rd_b", rd_b, 1'b1);
        @(negedge clk);
        #20 chk("m3 T2 adr15", adr15, 1'b1);
        mreq_b = 1'b1;
        wr_b   = 1'b1;
        @(negedge clk);
        #20 chk("m3 end adr15", adr15, 1'b0);
        mem_rd(16'h4000, 1'b0);

        // reset in the middle of an overdriven write
        io_out(6'b111000, 8'hC2, 2, 8'hC2);
        chk("cfg_q bank0 mode2", cfg_q, {6'd0, 3'd2});
        @(negedge clk);
        set_addr(16'h4000);
        mreq_b = 1'b0;
        wr_b   = 1'b0;
        @(negedge clk);
        #20 chk("rst T1 rd_b", rd_b, 1'b0);
        #30 reset_b = 1'b0;
        #5 chk("rst rd_b released", rd_b, 1'b1);
        chk("rst adr15 released", adr15, 1'b0);
        chk("rst cfg_q", cfg_q, 9'd0);
        m_mode = '0;
        m_bank = '0;
        check_map(16'h4000, 1'b1, 1'b0);
        mreq_b = 1'b1;
        wr_b   = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            ra = 6'($urandom);
            d1 = {2'b11, 6'($urandom)};
            d2 = {2'b11, 6'($urandom)};
            n  = int'($urandom_range(1, 4));
            io_out(ra, d1, n, d2);
            chk($sformatf("rand cfg_q %0d", k), cfg_q, {m_bank, m_mode});
            repeat (3) mem_rd(16'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
